// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: AHB-Lite slave backed by a DATA_WIDTH-wide word memory.
// Supports byte/halfword/word writes, WAIT_STATES data-phase wait cycles,
// and back-to-back pipelined transfers.
// Optional build macro AHB_SLAVE_ERR_EN adds the two-cycle ERROR response
// for out-of-range addresses, oversize HSIZE and misaligned addresses.
// Without the macro the index wraps modulo DEPTH, oversize HSIZE acts as a
// full-word access and misaligned low address bits are ignored.
module ahb_slave_mem #(
  parameter int BUS_WIDTH   = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [BUS_WIDTH-1:0]  HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFFW  = $clog2(BYTES);
  localparam int IDXW  = $clog2(DEPTH);
  localparam int ADDRW = IDXW + OFFW;

  localparam logic [2:0] WS      = 3'(WAIT_STATES);
  localparam logic [2:0] MAXSIZE = 3'(OFFW);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_DATA = 3'd2;
  localparam logic [2:0] ST_ERR1 = 3'd3;
  localparam logic [2:0] ST_ERR2 = 3'd4;

  logic [2:0]            r_state;
  logic [2:0]            r_cnt;
  logic [ADDRW-1:0]      r_addr;
  logic                  r_write;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_can_accept;
  logic                  w_accept;
  logic                  w_err;
  logic [IDXW-1:0]       w_idx;
  logic [OFFW-1:0]       w_off;
  logic [2:0]            w_eff_size;
  logic [BYTES-1:0]      w_strb;
  logic                  w_we;
  logic                  w_unused;

  // HTRANS[0] only distinguishes SEQ from NONSEQ, which this slave treats alike;
  // upper address bits only matter to the optional range check.
  assign w_unused = &{1'b0, HTRANS[0], HADDR};

  // A new address phase is taken only when no earlier transfer is still stalling the bus.
  always_comb begin
    w_can_accept = (r_state == ST_IDLE) || (r_state == ST_DATA) || (r_state == ST_ERR2);
    w_accept     = w_can_accept && HSEL && HREADY && HTRANS[1];
  end

`ifdef AHB_SLAVE_ERR_EN
  // Classify the incoming address phase: out of range, oversize, or misaligned.
  always_comb begin
    w_err = 1'b0;
    if ((HADDR >> ADDRW) != '0) begin
      w_err = 1'b1;
    end
    if (HSIZE > MAXSIZE) begin
      w_err = 1'b1;
    end
    for (int b = 0; b < OFFW; b++) begin
      if (HADDR[b] && (b < int'(HSIZE))) begin
        w_err = 1'b1;
      end
    end
  end
`else
  assign w_err = 1'b0;
`endif

  // Transfer sequencing: capture the address phase and walk IDLE/WAIT/DATA/ERR states.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= 3'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= HADDR[ADDRW-1:0];
        r_write <= HWRITE;
        r_size  <= HSIZE;
      end
      case (r_state)
        ST_IDLE, ST_DATA, ST_ERR2: begin
          if (w_accept) begin
            if (w_err) begin
              r_state <= ST_ERR1;
            end else if (WS != 3'd0) begin
              r_state <= ST_WAIT;
              r_cnt   <= WS;
            end else begin
              r_state <= ST_DATA;
            end
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (r_cnt <= 3'd1) begin
            r_state <= ST_DATA;
            r_cnt   <= 3'd0;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        ST_ERR1: r_state <= ST_ERR2;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Byte-lane selection: lanes sharing the size-aligned chunk with the address are written.
  always_comb begin
    w_idx      = r_addr[ADDRW-1:OFFW];
    w_off      = r_addr[OFFW-1:0];
    w_eff_size = (r_size > MAXSIZE) ? MAXSIZE : r_size;
    w_we       = (r_state == ST_DATA) && r_write && !HRESET;
    for (int b = 0; b < BYTES; b++) begin
      w_strb[b] = ((b >> w_eff_size) == (32'(w_off) >> w_eff_size));
    end
  end

  // Memory commit at the end of a write DATA cycle; contents survive reset.
  always_ff @(posedge HCLK) begin
    for (int b = 0; b < BYTES; b++) begin
      if (w_we && w_strb[b]) begin
        r_mem[w_idx][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  // Response outputs decoded from the registered state so reset clears them at once.
  always_comb begin
    HREADYOUT = !((r_state == ST_WAIT) || (r_state == ST_ERR1));
    HRESP     = (r_state == ST_ERR1) || (r_state == ST_ERR2);
    HRDATA    = ((r_state == ST_DATA) && !r_write) ? r_mem[w_idx] : '0;
  end

endmodule

// File: tb/tb_ahb_slave_mem.sv
// Testbench for ahb_slave_mem: two instances (0 and 3 wait states) driven by
// table vectors plus hand-written back-to-back, reset and idle sequences.
// Expectations follow the AHB_SLAVE_ERR_EN build macro when it is defined.
module tb_ahb_slave_mem;

`ifdef AHB_SLAVE_ERR_EN
  localparam bit ErrOn = 1'b1;
`else
  localparam bit ErrOn = 1'b0;
`endif

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] expData;
    logic        expResp;
    int          expLow;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        hsel      [2];
  logic [31:0] haddr     [2];
  logic [1:0]  htrans    [2];
  logic        hwrite    [2];
  logic [2:0]  hsize     [2];
  logic [31:0] hwdata    [2];
  logic        hready    [2];
  logic        forceLow  [2];
  logic [31:0] hrdata    [2];
  logic        hreadyout [2];
  logic        hresp     [2];

  int nChecks = 0;
  int nErrors = 0;

  vec_t vecs0[$];
  vec_t vecs3[$];

  always #5 clk = ~clk;

  // Single-slave bus: HREADY follows the slave, optionally pulled low by the bench.
  assign hready[0] = hreadyout[0] & ~forceLow[0];
  assign hready[1] = hreadyout[1] & ~forceLow[1];

  ahb_slave_mem #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(0)
  ) u_dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HREADY(hready[0]), .HRDATA(hrdata[0]),
    .HREADYOUT(hreadyout[0]), .HRESP(hresp[0])
  );

  ahb_slave_mem #(
    .BUS_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_STATES(3)
  ) u_dut3 (
    .HCLK(clk), .HRESET(rst), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HREADY(hready[1]), .HRDATA(hrdata[1]),
    .HREADYOUT(hreadyout[1]), .HRESP(hresp[1])
  );

  function automatic vec_t mkVec(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                 input logic [31:0] wdata, input logic [31:0] expData,
                                 input logic expResp, input int expLow);
    vec_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.wdata = wdata;
    v.expData = expData; v.expResp = expResp; v.expLow = expLow;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleBus(input int d);
    hsel[d]   = 1'b0;
    htrans[d] = 2'b00;
    hwrite[d] = 1'b0;
    haddr[d]  = 32'h0;
    hsize[d]  = 3'd2;
  endtask

  // One complete transfer starting at a negedge; returns at the negedge of its last data cycle.
  task automatic applyStimulus(input int d, input vec_t v, input string name);
    int          low;
    logic        done;
    logic        resp;
    logic [31:0] rdata;
    hsel[d]   = 1'b1;
    htrans[d] = 2'b10;
    haddr[d]  = v.addr;
    hwrite[d] = v.wr;
    hsize[d]  = v.size;
    @(posedge clk);
    #1;
    idleBus(d);
    hwdata[d] = v.wdata;
    low = 0; done = 1'b0; resp = 1'b0; rdata = 32'h0;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge clk);
      if (hreadyout[d]) begin
        done  = 1'b1;
        rdata = hrdata[d];
        resp  = hresp[d];
      end else begin
        low++;
      end
    end
    if (!done) begin
      nChecks++;
      nErrors++;
      $display("[TB] FAIL %s timeout: HREADYOUT stayed 0, expected 1 within 20 cycles", name);
    end
    checkOutput({name, " rdata"}, rdata, v.expData);
    checkOutput({name, " resp"}, 32'(resp), 32'(v.expResp));
    checkOutput({name, " waitCycles"}, 32'(low), 32'(v.expLow));
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic e;
    int   eLow;
    e    = ErrOn;
    eLow = ErrOn ? 1 : 0;

    // wait-state-free instance vectors
    vecs0.push_back(mkVec(1, 32'h000, 3'd2, 32'h0BADF00D, 32'h0, 0, 0));
    vecs0.push_back(mkVec(1, 32'h010, 3'd2, 32'h11223344, 32'h0, 0, 0));
    vecs0.push_back(mkVec(0, 32'h010, 3'd2, 32'h0, 32'h11223344, 0, 0));
    vecs0.push_back(mkVec(1, 32'h012, 3'd0, 32'hFFAAFFFF, 32'h0, 0, 0));
    vecs0.push_back(mkVec(0, 32'h010, 3'd2, 32'h0, 32'h11AA3344, 0, 0));
    vecs0.push_back(mkVec(1, 32'h014, 3'd2, 32'h55667788, 32'h0, 0, 0));
    vecs0.push_back(mkVec(1, 32'h016, 3'd1, 32'hBEEF0000, 32'h0, 0, 0));
    vecs0.push_back(mkVec(0, 32'h014, 3'd2, 32'h0, 32'hBEEF7788, 0, 0));
    vecs0.push_back(mkVec(1, 32'h3FC, 3'd2, 32'hCAFEF00D, 32'h0, 0, 0));
    vecs0.push_back(mkVec(0, 32'h3FC, 3'd2, 32'h0, 32'hCAFEF00D, 0, 0));
    vecs0.push_back(mkVec(1, 32'h400, 3'd2, 32'h12345678, 32'h0, e, eLow));
    vecs0.push_back(mkVec(0, 32'h000, 3'd2, 32'h0, ErrOn ? 32'h0BADF00D : 32'h12345678, 0, 0));
    vecs0.push_back(mkVec(0, 32'h410, 3'd2, 32'h0, ErrOn ? 32'h0 : 32'h11AA3344, e, eLow));
    vecs0.push_back(mkVec(1, 32'h024, 3'd2, 32'h01010101, 32'h0, 0, 0));
    vecs0.push_back(mkVec(1, 32'h024, 3'd3, 32'h9ABCDEF0, 32'h0, e, eLow));
    vecs0.push_back(mkVec(0, 32'h024, 3'd2, 32'h0, ErrOn ? 32'h01010101 : 32'h9ABCDEF0, 0, 0));
    vecs0.push_back(mkVec(1, 32'h028, 3'd2, 32'h00000000, 32'h0, 0, 0));
    vecs0.push_back(mkVec(1, 32'h029, 3'd2, 32'h13579BDF, 32'h0, e, eLow));
    vecs0.push_back(mkVec(0, 32'h028, 3'd2, 32'h0, ErrOn ? 32'h0 : 32'h13579BDF, 0, 0));
    vecs0.push_back(mkVec(1, 32'h02B, 3'd0, 32'h77000000, 32'h0, 0, 0));
    vecs0.push_back(mkVec(0, 32'h028, 3'd2, 32'h0, ErrOn ? 32'h77000000 : 32'h77579BDF, 0, 0));

    // three-wait-state instance vectors
    vecs3.push_back(mkVec(1, 32'h010, 3'd2, 32'hDEADBEEF, 32'h0, 0, 3));
    vecs3.push_back(mkVec(0, 32'h010, 3'd2, 32'h0, 32'hDEADBEEF, 0, 3));
    vecs3.push_back(mkVec(1, 32'h000, 3'd2, 32'h00000077, 32'h0, 0, 3));
    vecs3.push_back(mkVec(1, 32'h400, 3'd2, 32'h00000005, 32'h0, e, ErrOn ? 1 : 3));
    vecs3.push_back(mkVec(0, 32'h000, 3'd2, 32'h0, ErrOn ? 32'h77 : 32'h5, 0, 3));
    vecs3.push_back(mkVec(1, 32'h020, 3'd2, 32'h00000001, 32'h0, 0, 3));

    rst = 1'b1;
    forceLow[0] = 1'b0; forceLow[1] = 1'b0;
    hwdata[0] = 32'h0;  hwdata[1] = 32'h0;
    idleBus(0);
    idleBus(1);
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("reset%0d readyout", d), 32'(hreadyout[d]), 32'd1);
      checkOutput($sformatf("reset%0d resp", d), 32'(hresp[d]), 32'd0);
      checkOutput($sformatf("reset%0d rdata", d), hrdata[d], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs0.size(); i++) applyStimulus(0, vecs0[i], $sformatf("dut0 vec%0d", i));
    for (int i = 0; i < vecs3.size(); i++) applyStimulus(1, vecs3[i], $sformatf("dut3 vec%0d", i));
    @(negedge clk);

    // back-to-back write then read of 0x10 with no wait states
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h10; hwrite[0] = 1'b1; hsize[0] = 3'd2;
    @(posedge clk);
    #1;
    hwdata[0] = 32'hDEADBEEF;
    hwrite[0] = 1'b0;
    @(negedge clk);
    checkOutput("b2b write readyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("b2b write rdata", hrdata[0], 32'h0);
    @(posedge clk);
    #1;
    idleBus(0);
    @(negedge clk);
    checkOutput("b2b read readyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("b2b read rdata", hrdata[0], 32'hDEADBEEF);
    @(negedge clk);

    // address phase while HREADY is low must be ignored
    forceLow[0] = 1'b1;
    hsel[0] = 1'b1; htrans[0] = 2'b10; haddr[0] = 32'h10; hwrite[0] = 1'b0;
    @(posedge clk);
    #1;
    idleBus(0);
    forceLow[0] = 1'b0;
    @(negedge clk);
    checkOutput("hready low ignored rdata", hrdata[0], 32'h0);
    checkOutput("hready low ignored readyout", 32'(hreadyout[0]), 32'd1);

    // BUSY and unselected cycles get an OKAY zero-wait answer and start nothing
    hsel[0] = 1'b1; htrans[0] = 2'b01; haddr[0] = 32'h10; hwrite[0] = 1'b0;
    @(negedge clk);
    checkOutput("busy readyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("busy resp", 32'(hresp[0]), 32'd0);
    checkOutput("busy rdata", hrdata[0], 32'h0);
    hsel[0] = 1'b0; htrans[0] = 2'b10;
    @(negedge clk);
    checkOutput("unselected readyout", 32'(hreadyout[0]), 32'd1);
    checkOutput("unselected resp", 32'(hresp[0]), 32'd0);
    checkOutput("unselected rdata", hrdata[0], 32'h0);
    idleBus(0);
    @(negedge clk);

    // reset pulse in the WAIT phase of a write to 0x20 (which holds 0x1)
    hsel[1] = 1'b1; htrans[1] = 2'b10; haddr[1] = 32'h20; hwrite[1] = 1'b1; hsize[1] = 3'd2;
    @(posedge clk);
    #1;
    idleBus(1);
    hwdata[1] = 32'h0000FFFF;
    @(negedge clk);
    checkOutput("pre-reset wait readyout", 32'(hreadyout[1]), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async reset readyout", 32'(hreadyout[1]), 32'd1);
    checkOutput("async reset resp", 32'(hresp[1]), 32'd0);
    checkOutput("async reset rdata", hrdata[1], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("post-reset readyout", 32'(hreadyout[1]), 32'd1);
    applyStimulus(1, mkVec(0, 32'h020, 3'd2, 32'h0, 32'h00000001, 0, 3), "read after reset");
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
